// File: rtl/bloom_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bloom_counter_ctrl_pkg
// Brief    : Shared state encoding and default widths for the counting Bloom
//            filter controller.
// Revision : 1.0 - initial release
// ============================================================================
package bloom_counter_ctrl_pkg;

    localparam int DEF_HASH_BITS       = 19;
    localparam int DEF_SRAM_ADDR_WIDTH = 19;
    localparam int DEF_SRAM_DATA_WIDTH = 36;
    localparam int DEF_CNT_WIDTH       = 4;

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_RD0  = 6'b000010,
        S_RD1  = 6'b000100,
        S_WR0  = 6'b001000,
        S_WR1  = 6'b010000,
        S_DONE = 6'b100000
    } state_t;

endpackage : bloom_counter_ctrl_pkg
`default_nettype wire

// File: rtl/bloom_cnt_update.sv
`default_nettype none
// ============================================================================
// Module   : bloom_cnt_update
// Brief    : Next-value logic for one Bloom counter: saturating increment on
//            insert, decrement on an ACK hit, unchanged on an ACK miss.
// Revision : 1.0 - initial release
// ============================================================================
module bloom_cnt_update
    import bloom_counter_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic [CNT_WIDTH-1:0] cnt_in,
    input  logic                 is_ack,
    input  logic                 hit,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    always_comb begin
        sat = !is_ack && (cnt_in == CNT_MAX);
        if (is_ack) begin
            cnt_out = hit ? (cnt_in - CNT_ONE) : cnt_in;
        end else begin
            cnt_out = sat ? cnt_in : (cnt_in + CNT_ONE);
        end
    end

endmodule : bloom_cnt_update
`default_nettype wire

// File: rtl/bloom_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bloom_counter_ctrl
// Brief    : Counting Bloom filter of TCP flows kept in external SRAM; inserts
//            bump two counters, ACKs test and release them.
//            Optional statistics outputs: BLOOM_COUNTER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bloom_counter_ctrl
    import bloom_counter_ctrl_pkg::*;
#(
    parameter int HASH_BITS       = DEF_HASH_BITS,
    parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
    parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bloom_wr,
    output logic                       bloom_rdy,
    input  logic [HASH_BITS-1:0]       index_0,
    input  logic [HASH_BITS-1:0]       index_1,
    input  logic                       pkt_is_ack,
    output logic                       sram_req,
    output logic                       sram_rd_wr_L,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    input  logic                       sram_ack,
    output logic                       lookup_valid,
    output logic                       lookup_hit
`ifdef BLOOM_COUNTER_STATS_EN
    ,
    output logic [31:0]                num_inserts,
    output logic [31:0]                num_hits,
    output logic [31:0]                num_misses,
    output logic [31:0]                num_saturations
`endif
);

    state_t                     state_q, state_d;
    logic [HASH_BITS-1:0]       idx0_q, idx0_d, idx1_q, idx1_d;
    logic                       op_q, op_d, same_q, same_d, hit_q, hit_d;
    logic [CNT_WIDTH-1:0]       c0_q, c0_d, c1_q, c1_d;
    logic                       sram_req_q, sram_req_d, rd_wr_l_q, rd_wr_l_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                       lookup_valid_q, lookup_valid_d;
    logic                       lookup_hit_q, lookup_hit_d;
    logic                       bloom_rdy_q, bloom_rdy_d;

    logic [CNT_WIDTH-1:0]       rd_cnt, upd_in, upd_out;
    logic                       upd_sat;
    logic                       write_sat_done;

    assign rd_cnt = sram_rd_data[CNT_WIDTH-1:0];
    assign upd_in = (state_q == S_WR1) ? c1_q : c0_q;

    bloom_cnt_update #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_update (
        .cnt_in  (upd_in),
        .is_ack  (op_q),
        .hit     (hit_q),
        .cnt_out (upd_out),
        .sat     (upd_sat)
    );

    assign write_sat_done = ((state_q == S_WR0) || (state_q == S_WR1))
                            && sram_req_q && sram_ack && upd_sat;

    // Each access state first raises sram_req, then waits for sram_ack; the
    // ack edge drops the request, which gives the idle cycle between accesses.
    always_comb begin
        state_d        = state_q;
        idx0_d         = idx0_q;
        idx1_d         = idx1_q;
        op_d           = op_q;
        same_d         = same_q;
        hit_d          = hit_q;
        c0_d           = c0_q;
        c1_d           = c1_q;
        sram_req_d     = sram_req_q;
        rd_wr_l_d      = rd_wr_l_q;
        addr_d         = addr_q;
        wr_data_d      = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (bloom_wr && bloom_rdy_q) begin
                    idx0_d  = index_0;
                    idx1_d  = index_1;
                    op_d    = pkt_is_ack;
                    same_d  = (index_0 == index_1);
                    hit_d   = 1'b0;
                    state_d = S_RD0;
                end
            end
            S_RD0: begin
                if (!sram_req_q) begin
                    sram_req_d = 1'b1;
                    rd_wr_l_d  = 1'b1;
                    addr_d     = SRAM_ADDR_WIDTH'(idx0_q);
                end else if (sram_ack) begin
                    sram_req_d = 1'b0;
                    c0_d       = rd_cnt;
                    if (same_q) begin
                        hit_d   = (rd_cnt != '0);
                        state_d = (op_q && !hit_d) ? S_DONE : S_WR0;
                    end else begin
                        state_d = S_RD1;
                    end
                end
            end
            S_RD1: begin
                if (!sram_req_q) begin
                    sram_req_d = 1'b1;
                    rd_wr_l_d  = 1'b1;
                    addr_d     = SRAM_ADDR_WIDTH'(idx1_q);
                end else if (sram_ack) begin
                    sram_req_d = 1'b0;
                    c1_d       = rd_cnt;
                    hit_d      = (c0_q != '0) && (rd_cnt != '0);
                    // An ACK miss is resolved here so no write cycle is spent.
                    state_d    = (op_q && !hit_d) ? S_DONE : S_WR0;
                end
            end
            S_WR0: begin
                if (!sram_req_q) begin
                    sram_req_d = 1'b1;
                    rd_wr_l_d  = 1'b0;
                    addr_d     = SRAM_ADDR_WIDTH'(idx0_q);
                    wr_data_d  = SRAM_DATA_WIDTH'(upd_out);
                end else if (sram_ack) begin
                    sram_req_d = 1'b0;
                    state_d    = same_q ? S_DONE : S_WR1;
                end
            end
            S_WR1: begin
                if (!sram_req_q) begin
                    sram_req_d = 1'b1;
                    rd_wr_l_d  = 1'b0;
                    addr_d     = SRAM_ADDR_WIDTH'(idx1_q);
                    wr_data_d  = SRAM_DATA_WIDTH'(upd_out);
                end else if (sram_ack) begin
                    sram_req_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                sram_req_d = 1'b0;
            end
        endcase

        lookup_valid_d = (state_d == S_DONE);
        lookup_hit_d   = (state_d == S_DONE) && hit_d;
        bloom_rdy_d    = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx0_q         <= '0;
            idx1_q         <= '0;
            op_q           <= 1'b0;
            same_q         <= 1'b0;
            hit_q          <= 1'b0;
            c0_q           <= '0;
            c1_q           <= '0;
            sram_req_q     <= 1'b0;
            rd_wr_l_q      <= 1'b1;
            addr_q         <= '0;
            wr_data_q      <= '0;
            lookup_valid_q <= 1'b0;
            lookup_hit_q   <= 1'b0;
            bloom_rdy_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            idx0_q         <= idx0_d;
            idx1_q         <= idx1_d;
            op_q           <= op_d;
            same_q         <= same_d;
            hit_q          <= hit_d;
            c0_q           <= c0_d;
            c1_q           <= c1_d;
            sram_req_q     <= sram_req_d;
            rd_wr_l_q      <= rd_wr_l_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            lookup_valid_q <= lookup_valid_d;
            lookup_hit_q   <= lookup_hit_d;
            bloom_rdy_q    <= bloom_rdy_d;
        end
    end

    assign bloom_rdy    = bloom_rdy_q;
    assign sram_req     = sram_req_q;
    assign sram_rd_wr_L = rd_wr_l_q;
    assign sram_addr    = addr_q;
    assign sram_wr_data = wr_data_q;
    assign lookup_valid = lookup_valid_q;
    assign lookup_hit   = lookup_hit_q;

`ifdef BLOOM_COUNTER_STATS_EN
    logic [31:0] num_inserts_q, num_inserts_d;
    logic [31:0] num_hits_q, num_hits_d;
    logic [31:0] num_misses_q, num_misses_d;
    logic [31:0] num_sat_q, num_sat_d;

    always_comb begin
        num_inserts_d = num_inserts_q;
        num_hits_d    = num_hits_q;
        num_misses_d  = num_misses_q;
        num_sat_d     = num_sat_q;
        if (state_q == S_DONE) begin
            if (!op_q)      num_inserts_d = num_inserts_q + 32'd1;
            else if (hit_q) num_hits_d    = num_hits_q + 32'd1;
            else            num_misses_d  = num_misses_q + 32'd1;
        end
        if (write_sat_done) num_sat_d = num_sat_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_inserts_q <= '0;
            num_hits_q    <= '0;
            num_misses_q  <= '0;
            num_sat_q     <= '0;
        end else begin
            num_inserts_q <= num_inserts_d;
            num_hits_q    <= num_hits_d;
            num_misses_q  <= num_misses_d;
            num_sat_q     <= num_sat_d;
        end
    end

    assign num_inserts     = num_inserts_q;
    assign num_hits        = num_hits_q;
    assign num_misses      = num_misses_q;
    assign num_saturations = num_sat_q;

    logic unused_bits;
    assign unused_bits = ^sram_rd_data[SRAM_DATA_WIDTH-1:CNT_WIDTH];
`else
    logic unused_bits;
    assign unused_bits = ^{sram_rd_data[SRAM_DATA_WIDTH-1:CNT_WIDTH], write_sat_done};
`endif

endmodule : bloom_counter_ctrl
`default_nettype wire

// File: tb/tb_bloom_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bloom_counter_ctrl
// Brief    : Directed self-checking bench for bloom_counter_ctrl with a
//            behavioural SRAM of programmable ack latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bloom_counter_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bloom_wr;
    logic        bloom_rdy;
    logic [18:0] index_0, index_1;
    logic        pkt_is_ack;
    logic        sram_req, sram_rd_wr_L;
    logic [18:0] sram_addr;
    logic [35:0] sram_wr_data;
    logic [35:0] sram_rd_data = '0;
    logic        sram_ack = 1'b0;
    logic        lookup_valid, lookup_hit;
`ifdef BLOOM_COUNTER_STATS_EN
    logic [31:0] num_inserts, num_hits, num_misses, num_saturations;
`endif

    bloom_counter_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .bloom_wr     (bloom_wr),
        .bloom_rdy    (bloom_rdy),
        .index_0      (index_0),
        .index_1      (index_1),
        .pkt_is_ack   (pkt_is_ack),
        .sram_req     (sram_req),
        .sram_rd_wr_L (sram_rd_wr_L),
        .sram_addr    (sram_addr),
        .sram_wr_data (sram_wr_data),
        .sram_rd_data (sram_rd_data),
        .sram_ack     (sram_ack),
        .lookup_valid (lookup_valid),
        .lookup_hit   (lookup_hit)
`ifdef BLOOM_COUNTER_STATS_EN
        ,
        .num_inserts     (num_inserts),
        .num_hits        (num_hits),
        .num_misses      (num_misses),
        .num_saturations (num_saturations)
`endif
    );

    always #5 clk = ~clk;

    logic [35:0] mem [logic [18:0]];
    int          ack_delay = 1;
    int          req_cnt   = 0;
    int          n_reads   = 0;
    int          n_writes  = 0;
    int          lv_count  = 0;
    int          touched   = 0;
    int          stab_err  = 0;
    logic        prev_pend = 1'b0;
    logic [18:0] p_addr    = '0;
    logic [35:0] p_data    = '0;
    logic        p_rw      = 1'b1;

    int checks   = 0;
    int failures = 0;

    function automatic logic [35:0] rd_mem(input logic [18:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // SRAM model: ack after ack_delay cycles of sram_req, read data from mem
    always @(negedge clk) begin
        sram_ack     = sram_req && (req_cnt == ack_delay - 1);
        sram_rd_data = rd_mem(sram_addr);
    end

    always @(posedge clk) begin
        if (sram_req && sram_ack) begin
            if (sram_rd_wr_L) n_reads <= n_reads + 1;
            else begin
                n_writes <= n_writes + 1;
                mem[sram_addr] = sram_wr_data;
            end
            if (sram_addr == 19'h00700 || sram_addr == 19'h00701) touched <= touched + 1;
        end
        if (sram_req && !sram_ack) req_cnt <= req_cnt + 1;
        else                       req_cnt <= 0;
        if (prev_pend && sram_req &&
            (sram_addr !== p_addr || sram_wr_data !== p_data || sram_rd_wr_L !== p_rw))
            stab_err <= stab_err + 1;
        prev_pend <= sram_req && !sram_ack;
        p_addr    <= sram_addr;
        p_data    <= sram_wr_data;
        p_rw      <= sram_rd_wr_L;
        if (lookup_valid) lv_count <= lv_count + 1;
    end

    // Issues one request; lat is the cycle (accept edge = 0) lookup_valid is seen
    task automatic do_req(input logic [18:0] i0, input logic [18:0] i1, input logic ack,
                          input int pulse_at, output int lat, output logic hit,
                          output logic rdy1, output logic rdy_after);
        lat = -1; hit = 1'b0; rdy1 = 1'b1; rdy_after = 1'b0;
        @(negedge clk);
        bloom_wr = 1'b1; index_0 = i0; index_1 = i1; pkt_is_ack = ack;
        @(negedge clk);
        bloom_wr = 1'b0;
        rdy1 = bloom_rdy;
        for (int n = 1; n <= 400; n++) begin
            if (n > 1) @(negedge clk);
            if (n == pulse_at) begin
                bloom_wr = 1'b1; index_0 = 19'h00700; index_1 = 19'h00701; pkt_is_ack = 1'b1;
            end else begin
                bloom_wr = 1'b0;
            end
            if (lookup_valid) begin
                lat = n;
                hit = lookup_hit;
                break;
            end
        end
        bloom_wr = 1'b0;
        @(negedge clk);
        rdy_after = bloom_rdy;
    endtask

    initial begin
        int   lat, r0, w0, l0, s0;
        logic hit, rdy1, rdy_after, hit_first, found;

        reset = 1'b1; bloom_wr = 1'b0; index_0 = '0; index_1 = '0; pkt_is_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy",     bloom_rdy,    1);
        check("rst_req",     sram_req,     0);
        check("rst_rdwr",    sram_rd_wr_L, 1);
        check("rst_addr",    sram_addr,    0);
        check("rst_wdata",   sram_wr_data, 0);
        check("rst_valid",   lookup_valid, 0);
        check("rst_hit",     lookup_hit,   0);
        reset = 1'b0;

        // Insert on zeroed SRAM
        r0 = n_reads; w0 = n_writes;
        do_req(19'h00010, 19'h00020, 1'b0, 0, lat, hit, rdy1, rdy_after);
        check("ins_lat",      lat, 9);
        check("ins_hit",      hit, 0);
        check("ins_rdy_low",  rdy1, 0);
        check("ins_rdy_back", rdy_after, 1);
        check("ins_reads",    n_reads - r0, 2);
        check("ins_writes",   n_writes - w0, 2);
        check("ins_mem0",     rd_mem(19'h00010), 36'h1);
        check("ins_mem1",     rd_mem(19'h00020), 36'h1);

        // ACK hit on the same flow releases both counters
        r0 = n_reads; w0 = n_writes;
        do_req(19'h00010, 19'h00020, 1'b1, 0, lat, hit, rdy1, rdy_after);
        check("ackhit_lat",    lat, 9);
        check("ackhit_hit",    hit, 1);
        check("ackhit_reads",  n_reads - r0, 2);
        check("ackhit_writes", n_writes - w0, 2);
        check("ackhit_mem0",   rd_mem(19'h00010), 36'h0);
        check("ackhit_mem1",   rd_mem(19'h00020), 36'h0);

        // ACK miss: reads only
        r0 = n_reads; w0 = n_writes;
        do_req(19'h00030, 19'h00040, 1'b1, 0, lat, hit, rdy1, rdy_after);
        check("ackmiss_lat",    lat, 5);
        check("ackmiss_hit",    hit, 0);
        check("ackmiss_reads",  n_reads - r0, 2);
        check("ackmiss_writes", n_writes - w0, 0);
        check("ackmiss_rdy",    rdy_after, 1);

        // Equal indices: one access pair per request, saturating at 0xF
        r0 = n_reads; w0 = n_writes; hit_first = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            do_req(19'h7FFFF, 19'h7FFFF, 1'b0, 0, lat, hit, rdy1, rdy_after);
            if (k == 1)  hit_first = hit;
            if (k == 15) check("sat_mem15", rd_mem(19'h7FFFF), 36'hF);
        end
        check("sat_hit_first", hit_first, 0);
        check("sat_hit_last",  hit, 1);
        check("sat_lat",       lat, 5);
        check("sat_reads",     n_reads - r0, 17);
        check("sat_writes",    n_writes - w0, 17);
        check("sat_mem17",     rd_mem(19'h7FFFF), 36'hF);
`ifdef BLOOM_COUNTER_STATS_EN
        check("stat_sat",      num_saturations, 2);
        check("stat_inserts",  num_inserts, 18);
        check("stat_hits",     num_hits, 1);
        check("stat_misses",   num_misses, 1);
`endif

        // Stalled SRAM with a request strobe arriving mid-operation
        ack_delay = 7;
        l0 = lv_count; s0 = stab_err;
        do_req(19'h00500, 19'h00600, 1'b0, 5, lat, hit, rdy1, rdy_after);
        repeat (20) @(negedge clk);
        check("stall_lat",     lat, 33);
        check("stall_hit",     hit, 0);
        check("stall_valids",  lv_count - l0, 1);
        check("stall_stable",  stab_err - s0, 0);
        check("stall_ignored", touched, 0);
        check("stall_mem0",    rd_mem(19'h00500), 36'h1);
        check("stall_mem1",    rd_mem(19'h00600), 36'h1);

        // Reset while the second write is pending
        ack_delay = 3;
        found = 1'b0;
        @(negedge clk);
        bloom_wr = 1'b1; index_0 = 19'h00100; index_1 = 19'h00200; pkt_is_ack = 1'b0;
        @(negedge clk);
        bloom_wr = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (sram_req && !sram_rd_wr_L && sram_addr == 19'h00200) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_wr1_seen", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req", sram_req, 0);
        check("midrst_rdy", bloom_rdy, 1);
        reset = 1'b0;
        check("midrst_mem0", rd_mem(19'h00100), 36'h1);
        check("midrst_mem1", rd_mem(19'h00200), 36'h0);
        do_req(19'h00100, 19'h00200, 1'b0, 0, lat, hit, rdy1, rdy_after);
        check("post_lat",  lat, 17);
        check("post_hit",  hit, 0);
        check("post_mem0", rd_mem(19'h00100), 36'h2);
        check("post_mem1", rd_mem(19'h00200), 36'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bloom_counter_ctrl
`default_nettype wire
